// File: rtl/alu_operand_issue.sv
// RV64I issue stage: decodes one instruction bundle into ALU op/operands behind a
// registered valid/ready handshake, with an optional 1-entry skid buffer.
module alu_operand_issue #(
  parameter int XLEN    = 64,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0, ALU_SUB  = 4'h1, ALU_AND  = 4'h2, ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4, ALU_SLT  = 4'h5, ALU_SLTU = 4'h6, ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8, ALU_SRA  = 4'h9, ALU_ADDW = 4'hA, ALU_SUBW = 4'hB,
    ALU_SLLW = 4'hC, ALU_SRLW = 4'hD, ALU_SRAW = 4'hE
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP        = 7'b0110011,
    OPC_OP_IMM    = 7'b0010011,
    OPC_OP_32     = 7'b0111011,
    OPC_OP_IMM_32 = 7'b0011011,
    OPC_LUI       = 7'b0110111,
    OPC_AUIPC     = 7'b0010111
  } opcode_e;

  typedef struct packed {
    alu_op_e         op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic            illegal;
  } bundle_t;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Shared f3 map of OP/OP-IMM; alt selects sub/sra on the 000/101 slots.
  function automatic alu_op_e base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic            f7_ok;
  logic            legal;
  bundle_t         dec;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_u  = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
  // Register-register f7 rule: base always, alt only on add/sub and srl/sra slots.
  assign f7_ok  = (f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    dec    = '0;
    dec.rd = in_instr[11:7];
    legal  = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.a  = in_rs1;
        dec.b  = in_rs2;
        dec.op = base_op(f3, f7 == F7_ALT);
        legal  = f7_ok;
      end
      OPC_OP_IMM: begin
        dec.a  = in_rs1;
        dec.b  = imm_i;
        dec.op = base_op(f3, 1'b0);
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.b  = {{(XLEN-6){1'b0}}, in_instr[25:20]};
          dec.op = base_op(f3, in_instr[31:26] == 6'b010000);
          legal  = (in_instr[31:26] == 6'b000000) ||
                   (f3 == 3'b101 && in_instr[31:26] == 6'b010000);
        end
      end
      OPC_OP_32: begin
        dec.a = in_rs1;
        dec.b = in_rs2;
        case (f3)
          3'b000: begin dec.op = (f7 == F7_ALT) ? ALU_SUBW : ALU_ADDW; legal = f7_ok; end
          3'b001: begin dec.op = ALU_SLLW; legal = (f7 == F7_BASE); end
          3'b101: begin dec.op = (f7 == F7_ALT) ? ALU_SRAW : ALU_SRLW; legal = f7_ok; end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM_32: begin
        dec.a = in_rs1;
        dec.b = {{(XLEN-5){1'b0}}, in_instr[24:20]};
        case (f3)
          3'b000: begin dec.op = ALU_ADDW; dec.b = imm_i; end
          3'b001: begin dec.op = ALU_SLLW; legal = (f7 == F7_BASE); end
          3'b101: begin dec.op = (f7 == F7_ALT) ? ALU_SRAW : ALU_SRLW; legal = f7_ok; end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec.op = ALU_ADD;
        dec.b  = imm_u;
      end
      OPC_AUIPC: begin
        dec.op = ALU_ADD;
        dec.a  = in_pc;
        dec.b  = imm_u;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.op = ALU_ADD;
      dec.a  = '0;
      dec.b  = '0;
    end
    dec.illegal = !legal;
  end

  bundle_t out_q;
  bundle_t skid_q;
  logic    skid_full;
  logic    in_ready_q;
  logic    out_free;
  logic    accept;

  assign out_free = !out_valid || out_ready;
  // With SKID_EN=0 an accept only happens when the output is free, so the skid never fills.
  assign in_ready = SKID_EN ? in_ready_q : (!rst && out_free);
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_full  <= 1'b0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_full) begin
          out_q     <= skid_q;
          out_valid <= 1'b1;
          skid_full <= 1'b0;
        end else if (accept) begin
          out_q     <= dec;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_q    <= dec;
        skid_full <= 1'b1;
      end
      in_ready_q <= out_free || !(skid_full || accept);
    end
  end

  assign out_alu_op  = out_q.op;
  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_rd      = out_q.rd;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Scoreboard bench for alu_operand_issue: directed bundles, stall/skid, reset flush and
// randomized traffic against a field-level reference model.
module tb_alu_operand_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, in_rs1, in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [63:0] out_a, out_b;
  logic [4:0]  out_rd;
  logic        out_illegal;

  alu_operand_issue #(.XLEN(64), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit   rst_seen = 1'b0;
  bit   hold_valid = 1'b0;
  exp_t held;
  bit   s5_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input string name, input exp_t e);
    check({name, ".op"}, 64'(out_alu_op), 64'(e.op));
    check({name, ".a"}, out_a, e.a);
    check({name, ".b"}, out_b, e.b);
    check({name, ".rd"}, 64'(out_rd), 64'(e.rd));
    check({name, ".illegal"}, 64'(out_illegal), 64'(e.ill));
  endtask

  // Reference model: named-instruction semantics from the opcode/f3/f7 fields.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc,
                                 input logic [63:0] rs1, input logic [63:0] rs2);
    exp_t        e;
    logic [6:0]  opc = ins[6:0];
    logic [6:0]  f7 = ins[31:25];
    logic [2:0]  f3 = ins[14:12];
    longint      imm_i = $signed(ins[31:20]);
    longint      imm_u = $signed({ins[31:12], 12'h000});
    int          base[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    bit          alt = (f7 == 7'h20);
    bit          ok = 1'b0;
    int          op = 0;
    e.op = 4'h0; e.a = 64'h0; e.b = 64'h0; e.rd = ins[11:7]; e.ill = 1'b0;
    case (opc)
      7'h33, 7'h3B: begin
        // add->sub and srl->sra are the next code up
        ok = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
        op = base[f3] + ((alt && ok) ? 1 : 0);
        e.a = rs1; e.b = rs2;
        if (opc == 7'h3B) begin
          ok = ok && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5);
          op = (op == 0) ? 10 : (op == 1) ? 11 : (op == 7) ? 12 : (op == 8) ? 13 : 14;
        end
      end
      7'h13: begin
        e.a = rs1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = {58'h0, ins[25:20]};
          ok  = (ins[31:26] == 6'h00) || (f3 == 3'd5 && ins[31:26] == 6'h10);
          op  = base[f3] + ((ins[31:26] == 6'h10) ? 1 : 0);
        end else begin
          e.b = imm_i; ok = 1'b1; op = base[f3];
        end
      end
      7'h1B: begin
        e.a = rs1;
        if (f3 == 3'd0) begin
          ok = 1'b1; op = 10; e.b = imm_i;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = {59'h0, ins[24:20]};
          ok  = (f7 == 7'h00) || (f3 == 3'd5 && alt);
          op  = (f3 == 3'd1) ? 12 : (alt ? 14 : 13);
        end
      end
      7'h37: begin ok = 1'b1; e.b = imm_u; end
      7'h17: begin ok = 1'b1; e.a = pc; e.b = imm_u; end
      default: ok = 1'b0;
    endcase
    e.op = 4'(op);
    if (!ok) begin
      e.op = 4'h0; e.a = 64'h0; e.b = 64'h0; e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs[7] = '{7'h33, 7'h13, 7'h3B, 7'h1B, 7'h37, 7'h17, 7'h7F};
    logic [6:0] opc;
    logic [6:0] f7;
    if ($urandom_range(0, 15) == 0) return $urandom;
    opc = (($urandom_range(0, 9)) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 6)];
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  always @(posedge clk) rst_seen = rst;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: sample mid-cycle, check occupancy/stability, then pop/push the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      check("reset.out_valid", 64'(out_valid), 64'h0);
      check("reset.in_ready", 64'(in_ready), 64'h0);
      e.op = 4'h0; e.a = 64'h0; e.b = 64'h0; e.rd = 5'h0; e.ill = 1'b0;
      cmp_out("reset", e);
      hold_valid = 1'b0;
    end else if (!rst) begin
      check("occupancy.out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("occupancy.in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (hold_valid) begin
        check("stall.out_valid", 64'(out_valid), 64'h1);
        cmp_out("stall_hold", held);
      end
      hold_valid = 1'b0;
      if (out_valid && !out_ready) begin
        hold_valid = 1'b1;
        held.op = out_alu_op; held.a = out_a; held.b = out_b;
        held.rd = out_rd; held.ill = out_illegal;
      end
    end
    if (rst) begin
      q.delete();
      hold_valid = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got op=%h a=%h b=%h, expected no bundle", out_alu_op, out_a, out_b);
        end else begin
          e = q.pop_front();
          cmp_out("bundle", e);
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_instr, in_pc, in_rs1, in_rs2));
    end
  end

  // Drive a bundle at posedge+1 and hold it until accepted (bounded).
  task automatic send(input logic [31:0] ins, input logic [63:0] pc,
                      input logic [63:0] rs1, input logic [63:0] rs2);
    int n = 0;
    in_valid = 1'b1; in_instr = ins; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 64'h0;
    in_rs1 = 64'h0; in_rs2 = 64'h0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Directed decode cases at full throughput
    send(32'h002081B3, 64'h0, 64'd5, 64'd7);                       // add x3,x1,x2
    send(32'h43F0D093, 64'h0, 64'h8000_0000_0000_0000, 64'h0);     // srai x1,x1,63
    send({12'hFFF, 5'd1, 3'd0, 5'd1, 7'h1B}, 64'h0, 64'h1234, 64'h0); // addiw -1
    send({20'h12345, 5'd5, 7'h17}, 64'h1000, 64'h0, 64'h0);         // auipc
    send({20'h80000, 5'd1, 7'h37}, 64'h0, 64'hDEAD, 64'hBEEF);      // lui
    send({7'h01, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33}, 64'h0, 64'h11, 64'h22); // mul
    send({7'h01, 5'd3, 5'd1, 3'd1, 5'd1, 7'h1B}, 64'h0, 64'h33, 64'h0);  // slliw bad
    send(32'h0000007F, 64'h40, 64'h55, 64'h66);                     // unknown opcode
    send({7'h20, 5'd4, 5'd2, 3'd5, 5'd9, 7'h3B}, 64'h0, 64'h77, 64'h88); // sraw
    idle(3);

    // Stall with skid: 4 bundles, out_ready low for 3 cycles
    ready_mode = 2;
    fork
      begin
        send(32'h002081B3, 64'h0, 64'd1, 64'd1);
        send(32'h002081B3, 64'h0, 64'd2, 64'd2);
        send(32'h002081B3, 64'h0, 64'd3, 64'd3);
        send(32'h002081B3, 64'h0, 64'd4, 64'd4);
        s5_done = 1'b1;
      end
    join_none
    repeat (3) @(negedge clk);
    check("skid.in_ready_low", 64'(in_ready), 64'h0);
    @(posedge clk); #1;
    ready_mode = 0;
    for (int i = 0; i < 50 && !s5_done; i++) @(posedge clk);
    check("skid.stream_done", 64'(s5_done), 64'h1);
    idle(3);

    // Reset with output and skid both full
    ready_mode = 2;
    idle(1);
    send(32'h00208033, 64'h0, 64'hAA, 64'hBB);
    send(32'h40208033, 64'h0, 64'hCC, 64'hDD);
    in_valid = 1'b1; in_instr = 32'h00000013;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    ready_mode = 0;
    in_valid = 1'b0;
    idle(1);
    send(32'h0050C0B3, 64'h0, 64'hF0F0, 64'h0F0F);                  // xor
    idle(3);

    // Randomized traffic with random back-pressure
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(rand_instr(), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    ready_mode = 0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain.queue_empty", 64'(q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
